// File: rtl/fetch_pc_sequencer_if.sv
// Fetch-side bundle between the PC sequencer, the EX branch unit and IMEM.
// The master drives stall/branch/clear controls; the slave (sequencer) drives addresses and statistics.
interface fetch_pc_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic             stall;
  logic             br_valid;
  logic             take_branch;
  logic [31:0]      br_target;
  logic             cnt_clear;
  logic [31:0]      fetch_addr;
  logic [31:0]      pc_if;
  logic             if_valid;
  logic             redirect_pend;
  logic [CNT_W-1:0] cnt_taken;
  logic [CNT_W-1:0] cnt_not_taken;

  modport master (
    output stall, br_valid, take_branch, br_target, cnt_clear,
    input  fetch_addr, pc_if, if_valid, redirect_pend, cnt_taken, cnt_not_taken
  );

  modport slave (
    input  stall, br_valid, take_branch, br_target, cnt_clear,
    output fetch_addr, pc_if, if_valid, redirect_pend, cnt_taken, cnt_not_taken
  );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer for the 3-stage pipeline: drives IMEM address, applies EX redirects,
// parks a taken redirect that lands during a fetch stall, and keeps saturating branch counters.
module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input logic                 clk,
  input logic                 rst,
  fetch_pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      pc_q;
  logic [31:0]      pend_target;
  logic [31:0]      fetch_addr;
  logic             if_valid_q;
  logic             pend_q;
  logic [CNT_W-1:0] cnt_taken_q;
  logic [CNT_W-1:0] cnt_not_taken_q;
  logic             taken;

  assign taken = bus.br_valid & bus.take_branch;

  // A stall re-presents the current PC so IMEM returns the same instruction.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves fetch_addr unassigned (no latch).
    fetch_addr = RESET_PC;
    if (!rst) begin
      case (state)
        RUN:     fetch_addr = bus.stall ? pc_q : (taken ? bus.br_target : pc_q + 32'd4);
        HOLD:    fetch_addr = bus.stall ? pc_q : (taken ? bus.br_target : pend_target);
        default: fetch_addr = RESET_PC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state           <= BOOT;
      pc_q            <= RESET_PC;
      if_valid_q      <= 1'b0;
      pend_q          <= 1'b0;
      pend_target     <= 32'd0;
      cnt_taken_q     <= '0;
      cnt_not_taken_q <= '0;
    end else begin
      if (bus.cnt_clear) begin
        cnt_taken_q     <= '0;
        cnt_not_taken_q <= '0;
      end else if (bus.br_valid && state != BOOT) begin
        if (bus.take_branch) begin
          if (cnt_taken_q != '1) cnt_taken_q <= cnt_taken_q + CNT_W'(1);
        end else begin
          if (cnt_not_taken_q != '1) cnt_not_taken_q <= cnt_not_taken_q + CNT_W'(1);
        end
      end

      case (state)
        BOOT: begin
          pc_q       <= fetch_addr;
          if_valid_q <= 1'b1;
          state      <= RUN;
        end
        RUN: begin
          if (!bus.stall) begin
            pc_q <= fetch_addr;
          end else if (taken) begin
            pend_target <= bus.br_target;
            pend_q      <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          // The newest taken redirect wins while parked.
          if (bus.stall) begin
            if (taken) pend_target <= bus.br_target;
          end else begin
            pc_q   <= fetch_addr;
            pend_q <= 1'b0;
            state  <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign bus.fetch_addr    = fetch_addr;
  assign bus.pc_if         = pc_q;
  assign bus.if_valid      = if_valid_q;
  assign bus.redirect_pend = pend_q;
  assign bus.cnt_taken     = cnt_taken_q;
  assign bus.cnt_not_taken = cnt_not_taken_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Self-checking bench for fetch_pc_sequencer: directed vector table, hand-written corner
// sequences, then randomized traffic checked against a rule-level reference model.
module tb_fetch_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam int          CNT_W    = 4;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_pc_sequencer_if #(.CNT_W(CNT_W)) bus ();

  fetch_pc_sequencer #(
    .RESET_PC(RESET_PC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          m_known = 1'b0;
  bit          m_boot;
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_pend;
  logic [31:0] m_tgt;
  int          m_t;
  int          m_nt;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        bv;
    logic        tk;
    logic [31:0] tg;
    logic        clr;
    logic [31:0] e_fetch;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        e_pend;
    int          e_t;
    int          e_nt;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Expected IMEM address this cycle, from the redirect/stall rules.
  function automatic logic [31:0] exp_fetch();
    if (rst || m_boot) return RESET_PC;
    if (bus.stall) return m_pc;
    if (bus.br_valid && bus.take_branch) return bus.br_target;
    if (m_pend) return m_tgt;
    return m_pc + 32'd4;
  endfunction

  task automatic drive(input logic r, input logic s, input logic bv, input logic tk,
                       input logic [31:0] tg, input logic clr);
    @(negedge clk);
    rst             = r;
    bus.stall       = s;
    bus.br_valid    = bv;
    bus.take_branch = tk;
    bus.br_target   = tg;
    bus.cnt_clear   = clr;
    #1;
    if (m_known) begin
      check("model fetch_addr",    bus.fetch_addr,    exp_fetch());
      check("model pc_if",         bus.pc_if,         m_pc);
      check("model if_valid",      32'(bus.if_valid), 32'(m_valid));
      check("model redirect_pend", 32'(bus.redirect_pend), 32'(m_pend));
      check("model cnt_taken",     32'(bus.cnt_taken),     32'(m_t));
      check("model cnt_not_taken", 32'(bus.cnt_not_taken), 32'(m_nt));
    end
  endtask

  task automatic commit();
    logic [31:0] fa;
    logic        r, s, bv, tk, clr;
    logic [31:0] tg;
    fa  = exp_fetch();
    r   = rst;
    s   = bus.stall;
    bv  = bus.br_valid;
    tk  = bus.take_branch;
    tg  = bus.br_target;
    clr = bus.cnt_clear;
    @(posedge clk);
    if (r) begin
      m_known = 1'b1;
      m_boot  = 1'b1;
      m_pc    = RESET_PC;
      m_valid = 1'b0;
      m_pend  = 1'b0;
      m_tgt   = 32'd0;
      m_t     = 0;
      m_nt    = 0;
    end else if (m_known) begin
      if (clr) begin
        m_t  = 0;
        m_nt = 0;
      end else if (bv && !m_boot) begin
        if (tk) m_t  = (m_t  < CNT_MAX) ? m_t + 1  : CNT_MAX;
        else    m_nt = (m_nt < CNT_MAX) ? m_nt + 1 : CNT_MAX;
      end
      if (m_boot) begin
        m_pc    = RESET_PC;
        m_valid = 1'b1;
        m_boot  = 1'b0;
      end else if (!s) begin
        m_pc   = fa;
        m_pend = 1'b0;
      end else if (bv && tk) begin
        m_pend = 1'b1;
        m_tgt  = tg;
      end
    end
  endtask

  initial begin
    bus.stall       = 1'b0;
    bus.br_valid    = 1'b0;
    bus.take_branch = 1'b0;
    bus.br_target   = 32'd0;
    bus.cnt_clear   = 1'b0;

    //          rst stall bv tk target        clr  fetch          pc             vld pend t  nt
    vecs[0]  = '{1, 0, 0, 0, 32'h0,         0, 32'h4000_0000, 32'h4000_0000, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 32'h0,         0, 32'h4000_0000, 32'h4000_0000, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 32'h0,         0, 32'h4000_0000, 32'h4000_0000, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 32'h0,         0, 32'h4000_0004, 32'h4000_0000, 1, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 32'h0,         0, 32'h4000_0008, 32'h4000_0004, 1, 0, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 32'h0,         0, 32'h4000_000C, 32'h4000_0008, 1, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 32'h0,         0, 32'h4000_0010, 32'h4000_000C, 1, 0, 0, 0};
    vecs[7]  = '{0, 0, 1, 1, 32'h4000_0100, 0, 32'h4000_0100, 32'h4000_0010, 1, 0, 0, 0};
    vecs[8]  = '{0, 0, 1, 1, 32'h4000_0010, 0, 32'h4000_0010, 32'h4000_0100, 1, 0, 1, 0};
    vecs[9]  = '{0, 0, 1, 0, 32'hDEAD_BEEF, 0, 32'h4000_0014, 32'h4000_0010, 1, 0, 2, 0};
    vecs[10] = '{0, 0, 0, 0, 32'h0,         0, 32'h4000_0018, 32'h4000_0014, 1, 0, 2, 1};
    vecs[11] = '{0, 1, 0, 0, 32'h0,         0, 32'h4000_0018, 32'h4000_0018, 1, 0, 2, 1};
    vecs[12] = '{0, 1, 1, 1, 32'h4000_0200, 0, 32'h4000_0018, 32'h4000_0018, 1, 0, 2, 1};
    vecs[13] = '{0, 1, 0, 0, 32'h0,         0, 32'h4000_0018, 32'h4000_0018, 1, 1, 3, 1};
    vecs[14] = '{0, 0, 0, 0, 32'h0,         0, 32'h4000_0200, 32'h4000_0018, 1, 1, 3, 1};
    vecs[15] = '{0, 0, 0, 0, 32'h0,         0, 32'h4000_0204, 32'h4000_0200, 1, 0, 3, 1};
    vecs[16] = '{0, 1, 1, 1, 32'h4000_0300, 0, 32'h4000_0204, 32'h4000_0204, 1, 0, 3, 1};
    vecs[17] = '{1, 1, 0, 0, 32'h0,         0, 32'h4000_0000, 32'h4000_0204, 1, 1, 4, 1};
    vecs[18] = '{0, 0, 1, 1, 32'h4000_0500, 0, 32'h4000_0000, 32'h4000_0000, 0, 0, 0, 0};
    vecs[19] = '{0, 0, 0, 0, 32'h0,         0, 32'h4000_0004, 32'h4000_0000, 1, 0, 0, 0};

    // Preamble reset edge so every register is defined before the table starts.
    drive(1, 0, 0, 0, 32'h0, 0);
    commit();

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].bv, vecs[i].tk, vecs[i].tg, vecs[i].clr);
      check("vec fetch_addr",    bus.fetch_addr,              vecs[i].e_fetch);
      check("vec pc_if",         bus.pc_if,                   vecs[i].e_pc);
      check("vec if_valid",      32'(bus.if_valid),           32'(vecs[i].e_valid));
      check("vec redirect_pend", 32'(bus.redirect_pend),      32'(vecs[i].e_pend));
      check("vec cnt_taken",     32'(bus.cnt_taken),          32'(vecs[i].e_t));
      check("vec cnt_not_taken", 32'(bus.cnt_not_taken),      32'(vecs[i].e_nt));
      commit();
    end

    // 17 taken pulses saturate the 4-bit counter; the last lands on the top word.
    for (int i = 0; i < 17; i++) begin
      drive(0, 0, 1, 1, (i == 16) ? 32'hFFFF_FFFC : 32'h4000_1000 + 32'(i * 4), 0);
      commit();
    end
    drive(0, 0, 0, 0, 32'h0, 0);
    check("sat cnt_taken",   32'(bus.cnt_taken), 32'd15);
    check("wrap pc_if",      bus.pc_if,          32'hFFFF_FFFC);
    check("wrap fetch_addr", bus.fetch_addr,     32'h0000_0000);
    commit();

    drive(0, 0, 1, 1, 32'h4000_0040, 1);
    check("wrapped pc_if",       bus.pc_if,      32'h0000_0000);
    check("clear redirect addr", bus.fetch_addr, 32'h4000_0040);
    commit();
    drive(0, 0, 0, 0, 32'h0, 0);
    check("clear beats inc t",  32'(bus.cnt_taken),     32'd0);
    check("clear beats inc nt", 32'(bus.cnt_not_taken), 32'd0);
    check("post clear pc_if",   bus.pc_if,              32'h4000_0040);
    commit();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(logic'($urandom_range(0, 99) == 0),
            logic'($urandom_range(0, 2) == 0),
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 1)),
            32'($urandom),
            logic'($urandom_range(0, 49) == 0));
      commit();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
